beep_driver: RTL

BEEP_DRIVER -- requirements
Module: beep_driver

---
 rtl/beep_if.sv | 29 ++
 rtl/beep_driver.sv | 136 +++++++++++++
 2 files changed

// File: rtl/beep_if.sv
// Handshake and drive signals between a beep requester and beep_driver.
interface beep_if;
  logic       trig;
  logic [2:0] beeps;
  logic       abort;
  logic       buzzer;
  logic       busy;
  logic       done;

  // Requester side: issues trig/beeps/abort, observes status and drive.
  modport master (
    output trig,
    output beeps,
    output abort,
    input  buzzer,
    input  busy,
    input  done
  );

  // Driver side: consumes requests, produces drive and status.
  modport slave (
    input  trig,
    input  beeps,
    input  abort,
    output buzzer,
    output busy,
    output done
  );
endinterface

// File: rtl/beep_driver.sv
// Piezo beep sequencer: plays N tone bursts of ON_CYCLES separated by OFF_CYCLES
// of silence. The tone is a square wave toggling every TONE_HALF cycles.
// All outputs are registered; reset is asynchronous active-low.
module beep_driver #(
  parameter int unsigned TONE_HALF  = 5_000,
  parameter int unsigned ON_CYCLES  = 1_000_000,
  parameter int unsigned OFF_CYCLES = 1_000_000
) (
  input  logic   clk,
  input  logic   rst_n,
  beep_if.slave  bus
);

  localparam logic [19:0] OnLast   = 20'(ON_CYCLES - 1);
  localparam logic [19:0] OffLast  = 20'(OFF_CYCLES - 1);
  localparam logic [19:0] ToneLast = 20'(TONE_HALF - 1);

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  state_e      state_q, state_d;
  logic [2:0]  rem_q, rem_d;
  logic [19:0] cnt_q, cnt_d;
  logic [19:0] tone_q, tone_d;
  logic        buzzer_q, buzzer_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  rem_dec;

  assign rem_dec = rem_q - 3'd1;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q + 20'd1;
    tone_d   = tone_q + 20'd1;
    buzzer_d = buzzer_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d    = '0;
        tone_d   = '0;
        buzzer_d = 1'b0;
        busy_d   = 1'b0;
        // abort in the same cycle suppresses the request
        if (bus.trig && (bus.beeps != 3'd0) && !bus.abort) begin
          state_d  = StOn;
          rem_d    = bus.beeps;
          buzzer_d = 1'b1;
          busy_d   = 1'b1;
        end
      end

      StOn: begin
        if (bus.abort) begin
          state_d  = StIdle;
          rem_d    = '0;
          cnt_d    = '0;
          tone_d   = '0;
          buzzer_d = 1'b0;
          busy_d   = 1'b0;
        end else if (cnt_q == OnLast) begin
          rem_d    = rem_dec;
          cnt_d    = '0;
          tone_d   = '0;
          buzzer_d = 1'b0;
          if (rem_dec != 3'd0) begin
            state_d = StOff;
            busy_d  = 1'b1;
          end else begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else if (tone_q == ToneLast) begin
          buzzer_d = ~buzzer_q;
          tone_d   = '0;
        end
      end

      StOff: begin
        tone_d   = '0;
        buzzer_d = 1'b0;
        if (bus.abort) begin
          state_d = StIdle;
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == OffLast) begin
          // restart tone phase so each beep begins high
          state_d  = StOn;
          cnt_d    = '0;
          buzzer_d = 1'b1;
          busy_d   = 1'b1;
        end
      end

      default: begin
        state_d  = StIdle;
        rem_d    = '0;
        cnt_d    = '0;
        tone_d   = '0;
        buzzer_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      cnt_q    <= '0;
      tone_q   <= '0;
      buzzer_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      tone_q   <= tone_d;
      buzzer_q <= buzzer_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.buzzer = buzzer_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
